// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scan driver: geometry, FSM and frame-class
// encodings, and the frame classifier.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned CODE_W   = 5;
    localparam int unsigned REL_BIT  = 4;
    localparam int unsigned KEY_W    = CODE_W - 1;
    localparam int unsigned FRAME_W  = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StPressed,
        StReleaseDb
    } key_state_e;

    typedef enum logic [1:0] {
        FrEmpty,
        FrSingle,
        FrGhost
    } frame_class_e;

    typedef struct packed {
        frame_class_e     cls;
        logic [KEY_W-1:0] code;
    } frame_info_t;

    // Frame bit index is row*NUM_COLS+col, so the index of a lone set bit is the key code.
    function automatic frame_info_t classify_frame(input logic [FRAME_W-1:0] frame);
        frame_info_t info;
        int unsigned ones;
        info.cls  = FrEmpty;
        info.code = '0;
        ones      = 0;
        for (int i = 0; i < FRAME_W; i++) begin
            if (frame[i]) begin
                ones      = ones + 1;
                info.code = KEY_W'(i);
            end
        end
        if (ones == 0) begin
            info.cls = FrEmpty;
        end else if (ones == 1) begin
            info.cls = FrSingle;
        end else begin
            info.cls = FrGhost;
        end
        return info;
    endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// Column strobe generator: dwell counter, active-low column rotation, sample strobe on
// the last dwell cycle, and a one-cycle frame_end after the last column is sampled.
module keypad_col_driver
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [NUM_COLS-1:0]         col_n_o,
    output logic                        sample_o,
    output logic [$clog2(NUM_COLS)-1:0] col_idx_o,
    output logic                        frame_end_o
);

    localparam int unsigned DwellW = $clog2(SCAN_DIV);
    localparam int unsigned ColW   = $clog2(NUM_COLS);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
    localparam logic [ColW-1:0]   ColLast   = ColW'(NUM_COLS - 1);

    logic [DwellW-1:0]   dwell_q, dwell_d;
    logic [ColW-1:0]     col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] col_n_q, col_n_d;
    logic                frame_end_q, frame_end_d;
    logic                sample;

    // Next-state: count the dwell, rotate the low column after its sample.
    always_comb begin
        sample      = (dwell_q == DwellLast);
        dwell_d     = dwell_q + DwellW'(1);
        col_idx_d   = col_idx_q;
        col_n_d     = col_n_q;
        frame_end_d = 1'b0;
        if (sample) begin
            dwell_d     = '0;
            col_idx_d   = (col_idx_q == ColLast) ? '0 : col_idx_q + ColW'(1);
            col_n_d     = {col_n_q[NUM_COLS-2:0], col_n_q[NUM_COLS-1]};
            // Registered so the frame register already holds the last column's sample.
            frame_end_d = (col_idx_q == ColLast);
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q     <= '0;
            col_idx_q   <= '0;
            col_n_q     <= {{(NUM_COLS-1){1'b1}}, 1'b0};
            frame_end_q <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            col_n_q     <= col_n_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign col_n_o     = col_n_q;
    assign sample_o    = sample;
    assign col_idx_o   = col_idx_q;
    assign frame_end_o = frame_end_q;

endmodule

// File: rtl/keypad_scan_driver.sv
// 4x4 matrix keypad scanner: synchronises the rows, assembles one 16-bit frame per
// scan, debounces presses/releases over whole frames and presents key events on a
// valid/ready port with a sticky overrun flag.
// Define KEYPAD_RELEASE_EVT_EN to also emit release events ({1,code}).
module keypad_scan_driver
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned STABLE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NUM_COLS-1:0] col_n_o,
    input  logic [NUM_ROWS-1:0] row_n_i,
    output logic [CODE_W-1:0]   key_code_o,
    output logic                key_valid_o,
    input  logic                key_ready_i,
    output logic                key_held_o,
    output logic                overrun_o
);

`ifdef KEYPAD_RELEASE_EVT_EN
    localparam bit RelEvtEn = 1'b1;
`else
    localparam bit RelEvtEn = 1'b0;
`endif

    localparam int unsigned ColW = $clog2(NUM_COLS);
    localparam int unsigned CntW = $clog2(STABLE_SCANS + 1);
    localparam logic [CntW-1:0] StableCnt = CntW'(STABLE_SCANS);

    logic                sample;
    logic [ColW-1:0]     col_idx;
    logic                frame_end;

    logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    frame_info_t         info;

    key_state_e          state_q, state_d;
    logic [KEY_W-1:0]    cand_q, cand_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                evt_valid;
    logic [CODE_W-1:0]   evt_code;
    logic [CODE_W-1:0]   rel_code;

    logic [CODE_W-1:0]   key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                overrun_q, overrun_d;
    logic                xfer;

    keypad_col_driver #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_driver (
        .clk         (clk),
        .rst         (rst),
        .col_n_o     (col_n_o),
        .sample_o    (sample),
        .col_idx_o   (col_idx),
        .frame_end_o (frame_end)
    );

    // Two-flop synchroniser for the asynchronous rows; idle level is pulled-up high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= row_n_i;
            row_sync_q <= row_meta_q;
        end
    end

    // Frame assembly: write the active-high rows into the strobed column's bits.
    always_comb begin
        frame_d = frame_q;
        if (sample) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                frame_d[r*NUM_COLS + int'(col_idx)] = ~row_sync_q[r];
            end
        end
    end

    // Frame register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign info     = classify_frame(frame_q);
    assign rel_code = {RelEvtEn, cand_q};

    // Debounce FSM next-state and event generation, evaluated only on frame_end.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        cnt_inc   = cnt_q + CntW'(1);
        evt_valid = 1'b0;
        evt_code  = '0;
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (info.cls == FrSingle) begin
                        cand_d = info.code;
                        cnt_d  = CntW'(1);
                        if (STABLE_SCANS == 1) begin
                            state_d   = StPressed;
                            evt_valid = 1'b1;
                            evt_code  = {1'b0, info.code};
                        end else begin
                            state_d = StDebounce;
                        end
                    end
                end
                StDebounce: begin
                    if (info.cls == FrSingle && info.code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == StableCnt) begin
                            state_d   = StPressed;
                            evt_valid = 1'b1;
                            evt_code  = {1'b0, cand_q};
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
                StPressed: begin
                    // Any non-empty frame (other key, ghost) keeps the key held: no rollover.
                    if (info.cls == FrEmpty) begin
                        cnt_d = CntW'(1);
                        if (STABLE_SCANS == 1) begin
                            state_d   = StIdle;
                            evt_valid = RelEvtEn;
                            evt_code  = rel_code;
                        end else begin
                            state_d = StReleaseDb;
                        end
                    end
                end
                StReleaseDb: begin
                    if (info.cls == FrEmpty) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == StableCnt) begin
                            state_d   = StIdle;
                            evt_valid = RelEvtEn;
                            evt_code  = rel_code;
                        end
                    end else begin
                        state_d = StPressed;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output handshake: load on free slot or same-cycle transfer, else drop and flag.
    always_comb begin
        xfer        = key_valid_q && key_ready_i;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        overrun_d   = overrun_q;
        if (xfer) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (evt_valid) begin
            if (!key_valid_q || xfer) begin
                key_valid_d = 1'b1;
                key_code_d  = evt_code;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            overrun_q   <= overrun_d;
        end
    end

    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
    assign overrun_o   = overrun_q;
    assign key_held_o  = (state_q == StPressed) || (state_q == StReleaseDb);

endmodule

// File: tb/tb_keypad_scan_driver.sv
// Scoreboard bench for keypad_scan_driver with SCAN_DIV=4, STABLE_SCANS=3 (16-clk frame).
// Frame m is evaluated by the FSM on clock edge 16*m+1 counted from reset release.
`timescale 1ns/1ps
module tb_keypad_scan_driver;

    logic        clk;
    logic        rst;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [4:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_held;
    logic        overrun;

    logic [15:0] keys;
    int unsigned edges;
    int          checks;
    int          errors;
    logic [4:0]  sb[$];
    logic [4:0]  exp_code;

`ifdef KEYPAD_RELEASE_EVT_EN
    localparam bit RelEn = 1'b1;
`else
    localparam bit RelEn = 1'b0;
`endif

    keypad_scan_driver #(
        .SCAN_DIV     (4),
        .STABLE_SCANS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .col_n_o     (col_n),
        .row_n_i     (row_n),
        .key_code_o  (key_code),
        .key_valid_o (key_valid),
        .key_ready_i (key_ready),
        .key_held_o  (key_held),
        .overrun_o   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad: a pressed key at (r,c) pulls row r low while column c is low.
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    // Monitor: every transfer must match the head of the scoreboard.
    always begin
        @(negedge clk);
        #1;
        if (!rst && key_valid && key_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: key_code=%h, expected no event", key_code);
            end else begin
                exp_code = sb.pop_front();
                if (key_code !== exp_code) begin
                    errors++;
                    $display("FAIL event_code: key_code=%h, expected %h", key_code, exp_code);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_edges(input int unsigned n);
        while (edges < n) @(negedge clk);
    endtask

    // Reset asserted at a negedge; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        keys = '0;
        #1;
        check("rst_col_n", 32'(col_n), 32'h0e);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_held", 32'(key_held), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_key_code", 32'(key_code), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        keys      = '0;
        key_ready = 1'b0;

        // Test 1: reset mid-scan with a key pressed and an event pending.
        do_reset();
        key_ready = 1'b0;
        keys      = 16'h1 << 6;
        wait_edges(102);
        check("t1_held_before_rst", 32'(key_held), 32'h1);
        do_reset();

        // Test 2: key (1,2) -> press 5'h06 exactly one clock after the 3rd frame_end.
        key_ready = 1'b1;
        keys      = 16'h1 << 6;
        sb.push_back(5'h06);
        wait_edges(48);
        check("t2_valid_before", 32'(key_valid), 32'h0);
        wait_edges(49);
        check("t2_valid", 32'(key_valid), 32'h1);
        check("t2_code", 32'(key_code), 32'h06);
        check("t2_held", 32'(key_held), 32'h1);
        keys = '0;

        // Test 6: release after three empty frames.
        wait_edges(96);
        check("t6_held_before", 32'(key_held), 32'h1);
        check("t6_valid_before", 32'(key_valid), 32'h0);
        if (RelEn) sb.push_back(5'h16);
        wait_edges(97);
        check("t6_held_after", 32'(key_held), 32'h0);
        check("t6_valid_after", 32'(key_valid), 32'(RelEn));
        if (RelEn) check("t6_code", 32'(key_code), 32'h16);
        wait_edges(100);

        // Test 3: 2 frames present, 1 absent, 2 present -> never debounced.
        do_reset();
        key_ready = 1'b1;
        keys      = 16'h1 << 9;
        wait_edges(32);
        keys = '0;
        wait_edges(48);
        keys = 16'h1 << 9;
        wait_edges(80);
        keys = '0;
        wait_edges(120);
        check("t3_valid", 32'(key_valid), 32'h0);
        check("t3_held", 32'(key_held), 32'h0);

        // Test 4: consumer stalled; later events dropped and overrun set.
        do_reset();
        key_ready = 1'b0;
        keys      = 16'h1 << 6;
        sb.push_back(5'h06);
        wait_edges(49);
        keys = '0;
        wait_edges(97);
        check("t4_overrun_mid", 32'(overrun), 32'(RelEn));
        keys = 16'h1 << 0;
        wait_edges(150);
        check("t4_valid", 32'(key_valid), 32'h1);
        check("t4_code", 32'(key_code), 32'h06);
        check("t4_overrun", 32'(overrun), 32'h1);
        check("t4_held", 32'(key_held), 32'h1);
        key_ready = 1'b1;
        wait_edges(151);
        check("t4_valid_after", 32'(key_valid), 32'h0);
        check("t4_overrun_after", 32'(overrun), 32'h0);
        wait_edges(160);

        // Test 5: ghost frames (rows 0 and 3 on col 1), then a clean single key.
        do_reset();
        key_ready = 1'b1;
        keys      = (16'h1 << 1) | (16'h1 << 13);
        wait_edges(64);
        check("t5_valid_ghost", 32'(key_valid), 32'h0);
        check("t5_held_ghost", 32'(key_held), 32'h0);
        keys = 16'h1 << 1;
        sb.push_back(5'h01);
        wait_edges(112);
        check("t5_valid_before", 32'(key_valid), 32'h0);
        wait_edges(113);
        check("t5_valid", 32'(key_valid), 32'h1);
        check("t5_code", 32'(key_code), 32'h01);
        check("t5_held", 32'(key_held), 32'h1);
        wait_edges(120);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
